// File: rtl/sprite_draw_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// sprite_draw_scheduler_pkg
// Shared screen geometry, field widths and FSM state encoding for the sprite
// draw scheduler and its box walker.
// ----------------------------------------------------------------------------
package sprite_draw_scheduler_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int SIZE_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_ERASE  = 3'd2,
        S_DRAW   = 3'd3,
        S_NEXT   = 3'd4,
        S_FINISH = 3'd5
    } state_e;

    // True when an object's box differs from what was last drawn for it.
    function automatic logic box_changed(
        input logic [X_W-1:0]    x,
        input logic [X_W-1:0]    prev_x,
        input logic [Y_W-1:0]    y,
        input logic [Y_W-1:0]    prev_y,
        input logic [SIZE_W-1:0] size,
        input logic [SIZE_W-1:0] prev_size
    );
        return (x != prev_x) || (y != prev_y) || (size != prev_size);
    endfunction

endpackage

// File: rtl/sprite_draw_scheduler_box_walker.sv
// ----------------------------------------------------------------------------
// sprite_draw_scheduler_box_walker
// Walks a size x size box row-major (dx inner, dy outer) from a top-left base.
// Coordinates are formed one bit wider than the screen fields so that boxes
// hanging off the right/bottom edge are detected rather than wrapped.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   start_i          clear the dx/dy counters to the box origin
//   adv_i            step to the next pixel (wraps to origin after the last)
//   base_x_i/base_y_i/size_i   box description, held by the caller
//   cur_x_o/cur_y_o  current pixel coordinate (valid when in_bounds_o)
//   in_bounds_o      current pixel lies on screen
//   last_o           current pixel is the final one of the box
// ----------------------------------------------------------------------------
module sprite_draw_scheduler_box_walker
    import sprite_draw_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic              adv_i,
    input  logic [X_W-1:0]    base_x_i,
    input  logic [Y_W-1:0]    base_y_i,
    input  logic [SIZE_W-1:0] size_i,
    output logic [X_W-1:0]    cur_x_o,
    output logic [Y_W-1:0]    cur_y_o,
    output logic              in_bounds_o,
    output logic              last_o
);

    logic [SIZE_W-1:0] dx_q, dx_d;
    logic [SIZE_W-1:0] dy_q, dy_d;
    logic [X_W:0]      full_x;
    logic [Y_W:0]      full_y;
    logic              row_end;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        full_x      = (X_W+1)'(base_x_i) + (X_W+1)'(dx_q);
        full_y      = (Y_W+1)'(base_y_i) + (Y_W+1)'(dy_q);
        cur_x_o     = full_x[X_W-1:0];
        cur_y_o     = full_y[Y_W-1:0];
        in_bounds_o = (full_x < (X_W+1)'(SCREEN_W)) && (full_y < (Y_W+1)'(SCREEN_H));
        row_end     = (dx_q == size_i - SIZE_W'(1));
        last_o      = row_end && (dy_q == size_i - SIZE_W'(1));

        dx_d = dx_q;
        dy_d = dy_q;
        if (start_i) begin
            dx_d = '0;
            dy_d = '0;
        end else if (adv_i) begin
            if (row_end) begin
                dx_d = '0;
                dy_d = last_o ? '0 : dy_q + SIZE_W'(1);
            end else begin
                dx_d = dx_q + SIZE_W'(1);
            end
        end
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge value, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// ----------------------------------------------------------------------------
// sprite_draw_scheduler
// Per-frame sequencer sharing the single framebuffer write port among the
// player (object 0) and enemy objects. On each frame tick it visits every
// object; a moved/resized/removed object has its old box erased in BG_COLOUR,
// and a live moved/new object has its box drawn in its own colour.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   frame_tick_i       1-cycle redraw request
//   obj_valid_i        per-object live flag
//   obj_x_i/obj_y_i    per-object top-left corner (packed, object i at slice i)
//   obj_size_i         per-object box edge in pixels, 0 = not shown
//   obj_colour_i       per-object draw colour
//   pix_ready_i        framebuffer accepts the presented pixel this cycle
//   plot_o, pix_x_o, pix_y_o, pix_colour_o   pixel write request
//   busy_o             pass in progress
//   done_o             1-cycle pulse as a pass completes
//   overrun_o          1-cycle pulse when a frame tick had to be dropped
// ----------------------------------------------------------------------------
module sprite_draw_scheduler
    import sprite_draw_scheduler_pkg::*;
#(
    parameter int               NUM_OBJ   = 4,
    parameter logic [COL_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      frame_tick_i,
    input  logic [NUM_OBJ-1:0]        obj_valid_i,
    input  logic [X_W*NUM_OBJ-1:0]    obj_x_i,
    input  logic [Y_W*NUM_OBJ-1:0]    obj_y_i,
    input  logic [SIZE_W*NUM_OBJ-1:0] obj_size_i,
    input  logic [COL_W*NUM_OBJ-1:0]  obj_colour_i,
    input  logic                      pix_ready_i,
    output logic                      plot_o,
    output logic [X_W-1:0]            pix_x_o,
    output logic [Y_W-1:0]            pix_y_o,
    output logic [COL_W-1:0]          pix_colour_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overrun_o
);

    localparam int                 IDX_W    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_OBJ - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;

    // Snapshot of the object being serviced, taken in SELECT only.
    logic [X_W-1:0]     snap_x_q;
    logic [Y_W-1:0]     snap_y_q;
    logic [SIZE_W-1:0]  snap_size_q;
    logic [COL_W-1:0]   snap_col_q;
    logic               need_draw_q;

    // What is currently on screen for each object.
    logic [X_W-1:0]     prev_x_q    [NUM_OBJ];
    logic [Y_W-1:0]     prev_y_q    [NUM_OBJ];
    logic [SIZE_W-1:0]  prev_size_q [NUM_OBJ];
    logic [NUM_OBJ-1:0] drawn_q;

    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [SIZE_W-1:0]  sel_size;
    logic [COL_W-1:0]   sel_col;
    logic               live, changed, need_erase, need_draw;

    logic               box_state, step, box_end;
    logic               snap_en, erase_end, draw_end;
    logic [X_W-1:0]     walk_x, cur_x;
    logic [Y_W-1:0]     walk_y, cur_y;
    logic [SIZE_W-1:0]  walk_size;
    logic               in_bounds, last;

    // Object selection and erase/draw decision for the SELECT cycle.
    always_comb begin
        sel_x      = obj_x_i[idx_q*X_W +: X_W];
        sel_y      = obj_y_i[idx_q*Y_W +: Y_W];
        sel_size   = obj_size_i[idx_q*SIZE_W +: SIZE_W];
        sel_col    = obj_colour_i[idx_q*COL_W +: COL_W];
        live       = obj_valid_i[idx_q] && (sel_size != '0);
        changed    = box_changed(sel_x, prev_x_q[idx_q], sel_y, prev_y_q[idx_q],
                                 sel_size, prev_size_q[idx_q]);
        need_erase = drawn_q[idx_q] && (!live || changed);
        need_draw  = live && (!drawn_q[idx_q] || changed);
    end

    // Erase walks the previously drawn box; draw walks the snapshot.
    always_comb begin
        box_state = (state_q == S_ERASE) || (state_q == S_DRAW);
        walk_x    = (state_q == S_ERASE) ? prev_x_q[idx_q]    : snap_x_q;
        walk_y    = (state_q == S_ERASE) ? prev_y_q[idx_q]    : snap_y_q;
        walk_size = (state_q == S_ERASE) ? prev_size_q[idx_q] : snap_size_q;
        // Clipped pixels are skipped in one cycle without waiting for ready.
        step      = box_state && (!in_bounds || pix_ready_i);
        box_end   = step && last;
    end

    sprite_draw_scheduler_box_walker u_walker (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (state_q == S_SELECT),
        .adv_i       (step),
        .base_x_i    (walk_x),
        .base_y_i    (walk_y),
        .size_i      (walk_size),
        .cur_x_o     (cur_x),
        .cur_y_o     (cur_y),
        .in_bounds_o (in_bounds),
        .last_o      (last)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        overrun_d = 1'b0;
        snap_en   = 1'b0;
        erase_end = 1'b0;
        draw_end  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (frame_tick_i || pending_q) begin
                    state_d   = S_SELECT;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            S_SELECT: begin
                snap_en = 1'b1;
                if (need_erase)     state_d = S_ERASE;
                else if (need_draw) state_d = S_DRAW;
                else                state_d = S_NEXT;
            end
            S_ERASE: begin
                if (box_end) begin
                    erase_end = 1'b1;
                    state_d   = need_draw_q ? S_DRAW : S_NEXT;
                end
            end
            S_DRAW: begin
                if (box_end) begin
                    draw_end = 1'b1;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_SELECT;
                end
            end
            S_FINISH: begin
                if (pending_q) begin
                    state_d = S_SELECT;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // FINISH consumes any pending request, so a tick landing there simply
        // becomes the new pending one. Elsewhere while busy the request is
        // queued one deep and anything beyond that is dropped.
        if (state_q == S_FINISH) begin
            pending_d = frame_tick_i;
        end else if ((state_q != S_IDLE) && frame_tick_i) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the per-object prev/drawn arrays are reset explicitly; a restart
    // must never erase a box that was not drawn since reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            snap_size_q <= '0;
            snap_col_q  <= '0;
            need_draw_q <= 1'b0;
            drawn_q     <= '0;
            for (int k = 0; k < NUM_OBJ; k++) begin
                prev_x_q[k]    <= '0;
                prev_y_q[k]    <= '0;
                prev_size_q[k] <= '0;
            end
        end else begin
            if (snap_en) begin
                snap_x_q    <= sel_x;
                snap_y_q    <= sel_y;
                snap_size_q <= sel_size;
                snap_col_q  <= sel_col;
                need_draw_q <= need_draw;
            end
            if (erase_end && !need_draw_q) begin
                drawn_q[idx_q] <= 1'b0;
            end
            if (draw_end) begin
                prev_x_q[idx_q]    <= snap_x_q;
                prev_y_q[idx_q]    <= snap_y_q;
                prev_size_q[idx_q] <= snap_size_q;
                drawn_q[idx_q]     <= 1'b1;
            end
        end
    end

    // Outputs depend only on registered state, so they stay stable while a
    // pixel waits for pix_ready_i.
    always_comb begin
        plot_o       = box_state && in_bounds;
        pix_x_o      = plot_o ? cur_x : '0;
        pix_y_o      = plot_o ? cur_y : '0;
        pix_colour_o = '0;
        if (plot_o) pix_colour_o = (state_q == S_ERASE) ? BG_COLOUR : snap_col_q;
        done_o       = (state_q == S_FINISH);
        busy_o       = (state_q != S_IDLE) && !((state_q == S_FINISH) && !pending_q);
        overrun_o    = overrun_q;
    end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
module tb_sprite_draw_scheduler;

    localparam int NUM_OBJ = 4;

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic                   frame_tick = 1'b0;
    logic                   pix_ready = 1'b1;
    logic [NUM_OBJ-1:0]     obj_valid;
    logic [8*NUM_OBJ-1:0]   obj_x;
    logic [7*NUM_OBJ-1:0]   obj_y;
    logic [3*NUM_OBJ-1:0]   obj_size;
    logic [3*NUM_OBJ-1:0]   obj_colour;
    logic                   plot;
    logic [7:0]             pix_x;
    logic [6:0]             pix_y;
    logic [2:0]             pix_colour;
    logic                   busy, done, overrun;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t sb[$];
    pix_t exp_pix;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   acc_cnt  = 0;
    int   ovr_cnt  = 0;

    bit   ov   [NUM_OBJ];
    int   ox   [NUM_OBJ];
    int   oy   [NUM_OBJ];
    int   osz  [NUM_OBJ];
    int   ocol [NUM_OBJ];

    always #5 clk = ~clk;

    sprite_draw_scheduler #(.NUM_OBJ(NUM_OBJ), .BG_COLOUR(3'b000)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .frame_tick_i (frame_tick),
        .obj_valid_i  (obj_valid),
        .obj_x_i      (obj_x),
        .obj_y_i      (obj_y),
        .obj_size_i   (obj_size),
        .obj_colour_i (obj_colour),
        .pix_ready_i  (pix_ready),
        .plot_o       (plot),
        .pix_x_o      (pix_x),
        .pix_y_o      (pix_y),
        .pix_colour_o (pix_colour),
        .busy_o       (busy),
        .done_o       (done),
        .overrun_o    (overrun)
    );

    // Scoreboard consumer: every accepted pixel must be the next expected one.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (overrun) ovr_cnt++;
            if (plot && pix_ready) begin
                acc_cnt++;
                chk_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL pixel_unexpected: got (%0d,%0d) col %b, expected no pixel",
                             pix_x, pix_y, pix_colour);
                end else begin
                    exp_pix = sb.pop_front();
                    if ({pix_x, pix_y, pix_colour} !== exp_pix)
                        $display("FAIL pixel: got (%0d,%0d) col %b, expected (%0d,%0d) col %b",
                                 pix_x, pix_y, pix_colour, exp_pix.x, exp_pix.y, exp_pix.c);
                    else
                        pass_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    task automatic set_obj(input int k, input bit v, input int x, input int y,
                           input int s, input int c);
        ov[k] = v; ox[k] = x; oy[k] = y; osz[k] = s; ocol[k] = c;
    endtask

    task automatic apply_objs();
        @(posedge clk); #1;
        for (int k = 0; k < NUM_OBJ; k++) begin
            obj_valid[k]        = ov[k];
            obj_x[k*8 +: 8]      = 8'(ox[k]);
            obj_y[k*7 +: 7]      = 7'(oy[k]);
            obj_size[k*3 +: 3]   = 3'(osz[k]);
            obj_colour[k*3 +: 3] = 3'(ocol[k]);
        end
    endtask

    // Reference model of the box walk with screen clipping.
    task automatic push_box(input int x, input int y, input int s, input int c);
        pix_t p;
        for (int dy = 0; dy < s; dy++)
            for (int dx = 0; dx < s; dx++)
                if ((x + dx) < 160 && (y + dy) < 120) begin
                    p.x = 8'(x + dx);
                    p.y = 7'(y + dy);
                    p.c = 3'(c);
                    sb.push_back(p);
                end
    endtask

    task automatic do_tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
    endtask

    // Observe a pass from its SELECT cycle until done, bounded.
    task automatic measure(output int busy_n, output int plots_n,
                           output int first_plot, output bit ok);
        int base;
        base = acc_cnt; busy_n = 0; first_plot = -1; ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
            if (busy) busy_n++;
            if (plot && first_plot < 0) first_plot = k;
        end
        plots_n = acc_cnt - base;
    endtask

    task automatic run_pass(input string name, input int exp_busy, input int exp_plots);
        int b, p, f; bit ok;
        do_tick();
        measure(b, p, f, ok);
        chk_cnt++;
        if (ok !== 1'b1) $display("FAIL %s_done: no done within 2000 cycles, expected done", name);
        else pass_cnt++;
        chk_cnt++;
        if (b != exp_busy) $display("FAIL %s_busy: got %0d busy cycles, expected %0d", name, b, exp_busy);
        else pass_cnt++;
        chk_cnt++;
        if (p != exp_plots) $display("FAIL %s_plots: got %0d plots, expected %0d", name, p, exp_plots);
        else pass_cnt++;
        chk_cnt++;
        if (sb.size() != 0) $display("FAIL %s_leftover: got %0d unplotted pixels, expected 0", name, sb.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({plot, busy, done, overrun} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b, expected 0000", {plot, busy, done, overrun});
        else pass_cnt++;
        chk_cnt++;
        if ({pix_x, pix_y, pix_colour} !== 18'd0)
            $display("FAIL reset_pix: got %h, expected 0", {pix_x, pix_y, pix_colour});
        else pass_cnt++;
        @(posedge clk); #1 resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({plot, busy, done, overrun} !== 4'b0000)
            $display("FAIL reset_idle: got %b, expected 0000", {plot, busy, done, overrun});
        else pass_cnt++;
    endtask

    task automatic test_single_draw();
        int b, p, f; bit ok;
        set_obj(0, 1'b1, 10, 20, 2, 3'b010);
        apply_objs();
        push_box(10, 20, 2, 3'b010);
        do_tick();
        measure(b, p, f, ok);
        chk_cnt++;
        if (ok !== 1'b1) $display("FAIL single_done: no done within 2000 cycles, expected done");
        else pass_cnt++;
        chk_cnt++;
        if (b != 12) $display("FAIL single_busy: got %0d busy cycles, expected 12", b);
        else pass_cnt++;
        chk_cnt++;
        if (p != 4) $display("FAIL single_plots: got %0d plots, expected 4", p);
        else pass_cnt++;
        chk_cnt++;
        if (f != 1) $display("FAIL single_latency: first plot at cycle %0d after SELECT start, expected 1", f);
        else pass_cnt++;
        chk_cnt++;
        if (sb.size() != 0) $display("FAIL single_leftover: got %0d unplotted pixels, expected 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_move();
        set_obj(0, 1'b1, 11, 20, 2, 3'b010);
        apply_objs();
        push_box(10, 20, 2, 3'b000);
        push_box(11, 20, 2, 3'b010);
        run_pass("move", 16, 8);
        run_pass("static", 8, 0);
    endtask

    task automatic test_clip();
        set_obj(1, 1'b1, 159, 119, 3, 3'b101);
        apply_objs();
        push_box(159, 119, 3, 3'b101);
        run_pass("clip", 17, 1);
    endtask

    task automatic test_stall();
        int b, p, f, base; bit ok, seen;
        logic [7:0] hx; logic [6:0] hy;
        set_obj(0, 1'b1, 30, 40, 3, 3'b110);
        apply_objs();
        push_box(11, 20, 2, 3'b000);
        push_box(30, 40, 3, 3'b110);
        base = acc_cnt;
        do_tick();
        fork
            measure(b, p, f, ok);
            begin
                seen = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (acc_cnt >= base + 6) begin seen = 1'b1; break; end
                end
                chk_cnt++;
                if (!seen) $display("FAIL stall_reach: fewer than 6 pixels in 200 cycles, expected 6");
                else pass_cnt++;
                @(posedge clk); #1 pix_ready = 1'b0;
                @(negedge clk);
                hx = pix_x; hy = pix_y;
                chk_cnt++;
                if (plot !== 1'b1) $display("FAIL stall_plot0: got plot %b, expected 1", plot);
                else pass_cnt++;
                for (int k = 1; k < 5; k++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk_cnt++;
                    if ({plot, pix_x, pix_y} !== {1'b1, hx, hy})
                        $display("FAIL stall_hold: cycle %0d got plot %b (%0d,%0d), expected 1 (%0d,%0d)",
                                 k, plot, pix_x, pix_y, hx, hy);
                    else pass_cnt++;
                end
                @(posedge clk); #1 pix_ready = 1'b1;
            end
        join
        chk_cnt++;
        if (!ok) $display("FAIL stall_done: no done within 2000 cycles, expected done");
        else pass_cnt++;
        chk_cnt++;
        if (b != 26) $display("FAIL stall_busy: got %0d busy cycles, expected 26", b);
        else pass_cnt++;
        chk_cnt++;
        if (p != 13 || sb.size() != 0)
            $display("FAIL stall_plots: got %0d plots with %0d left, expected 13 with 0 left", p, sb.size());
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int base_ovr, bcnt, gap, dones; bit ok; logic busy_first, busy_second;
        base_ovr = ovr_cnt; bcnt = 0; gap = 0; dones = 0; ok = 1'b0;
        busy_first = 1'b0; busy_second = 1'b1;
        do_tick();
        fork
            begin
                @(posedge clk); #1 frame_tick = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1 frame_tick = 1'b0;
            end
            begin
                for (int k = 0; k < 2000; k++) begin
                    @(negedge clk);
                    if (busy) bcnt++;
                    if (done) begin
                        dones++;
                        if (dones == 1) busy_first = busy;
                        else begin busy_second = busy; ok = 1'b1; break; end
                    end else if (!busy) begin
                        gap++;
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (!ok) $display("FAIL ovr_done: got %0d done pulses in 2000 cycles, expected 2", dones);
        else pass_cnt++;
        chk_cnt++;
        if (ovr_cnt - base_ovr != 1) $display("FAIL ovr_count: got %0d overrun pulses, expected 1", ovr_cnt - base_ovr);
        else pass_cnt++;
        chk_cnt++;
        if (gap != 0) $display("FAIL ovr_idle_gap: got %0d idle cycles between passes, expected 0", gap);
        else pass_cnt++;
        chk_cnt++;
        if ({busy_first, busy_second} !== 2'b10)
            $display("FAIL ovr_busy_at_done: got %b, expected 10", {busy_first, busy_second});
        else pass_cnt++;
        chk_cnt++;
        if (bcnt != 17) $display("FAIL ovr_busy: got %0d busy cycles, expected 17", bcnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_pass();
        int base; bit seen;
        set_obj(0, 1'b1, 50, 40, 3, 3'b110);
        apply_objs();
        push_box(30, 40, 3, 3'b000);
        base = acc_cnt; seen = 1'b0;
        do_tick();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (acc_cnt >= base + 3) begin seen = 1'b1; break; end
        end
        chk_cnt++;
        if (!seen) $display("FAIL rst_reach: fewer than 3 erase pixels in 200 cycles, expected 3");
        else pass_cnt++;
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({plot, busy, done} !== 3'b000)
            $display("FAIL rst_abort: got plot/busy/done %b, expected 000", {plot, busy, done});
        else pass_cnt++;
        sb.delete();
        @(posedge clk); #1 resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({plot, busy} !== 2'b00) $display("FAIL rst_quiet: got plot/busy %b, expected 00", {plot, busy});
        else pass_cnt++;
        push_box(50, 40, 3, 3'b110);
        push_box(159, 119, 3, 3'b101);
        run_pass("fresh", 26, 10);
    endtask

    initial begin : main
        for (int k = 0; k < NUM_OBJ; k++) set_obj(k, 1'b0, 0, 0, 1, 0);
        set_obj(2, 1'b1, 5, 5, 0, 3'b111);
        obj_valid = '0; obj_x = '0; obj_y = '0; obj_size = '0; obj_colour = '0;
        apply_objs();
        test_reset();
        test_single_draw();
        test_move();
        test_clip();
        test_stall();
        test_overrun();
        test_reset_mid_pass();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
